// File: rtl/spi_master_ctrl.sv
// SPI master: one FRAME_WIDTH frame per start, CPOL/CPHA, SCLK half-period clk_div+1; done at cycle 1+H*(2*FRAME_WIDTH+2).
// A start that arrives while busy is dropped. The SPI_LSB_FIRST_EN macro adds a per-transfer lsb_first input.
module spi_master_ctrl #(
  parameter int FRAME_WIDTH = 16,
  parameter int SS_NUM      = 2,
  parameter int DIV_WIDTH   = 8,
  localparam int SSW        = (SS_NUM > 1) ? $clog2(SS_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [FRAME_WIDTH-1:0] tx_data,
  input  logic [SSW-1:0]         ss_sel,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [DIV_WIDTH-1:0]   clk_div,
`ifdef SPI_LSB_FIRST_EN
  input  logic                   lsb_first,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic [SS_NUM-1:0]      ss
);

  localparam int EW = $clog2(2*FRAME_WIDTH+1);
  localparam logic [EW-1:0] EDGES     = EW'(2*FRAME_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*FRAME_WIDTH-1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                 r_state, w_next;
  logic [DIV_WIDTH-1:0]   r_cnt, r_div;
  logic [EW-1:0]          r_edge;
  logic [FRAME_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [SSW-1:0]         r_ss_sel;
  logic                   r_cpol, r_cpha, r_sclk, r_mosi, r_done;
  logic                   w_lsb, w_lsb_in;
  logic                   w_tick, w_toggle, w_lead, w_sample, w_drive;
  logic                   w_tx_bit, w_acc_bit;
  logic [FRAME_WIDTH-1:0] w_tx_shl, w_acc_shl;
  logic [SS_NUM-1:0]      w_ss;

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb    = r_lsb;
  assign w_lsb_in = lsb_first;
`else
  assign w_lsb    = 1'b0;
  assign w_lsb_in = 1'b0;
`endif

  // r_edge counts SCLK edges already issued, so the upcoming edge is leading when it is even
  assign w_tick    = (r_cnt == r_div);
  assign w_toggle  = w_tick && ((r_state == SETUP) || (r_state == XFER && r_edge != EDGES));
  assign w_lead    = ~r_edge[0];
  assign w_sample  = w_toggle && (w_lead ^ r_cpha);
  assign w_drive   = w_toggle && (r_cpha ? w_lead : (!w_lead && r_edge != LAST_EDGE));
  assign w_tx_bit  = w_lsb ? r_tx[0] : r_tx[FRAME_WIDTH-1];
  assign w_tx_shl  = w_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_acc_bit = w_lsb_in ? tx_data[0] : tx_data[FRAME_WIDTH-1];
  assign w_acc_shl = w_lsb_in ? (tx_data >> 1) : (tx_data << 1);

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = (r_state == XFER) ? r_sclk : r_cpol;
  assign mosi    = r_mosi;
  assign ss      = w_ss;

  always_comb begin
    w_ss = '1;
    for (int i = 0; i < SS_NUM; i++)
      if (busy && r_ss_sel == SSW'(i)) w_ss[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETUP;
      SETUP:   if (w_tick) w_next = XFER;
      XFER:    if (w_tick && r_edge == EDGES) w_next = HOLD;
      HOLD:    if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_edge   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_ss_sel <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_div    <= '0;
`ifdef SPI_LSB_FIRST_EN
      r_lsb    <= 1'b0;
`endif
      // an aborted transfer leaves the last completed frame visible
      if (r_state == IDLE) r_rx_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_mosi <= 1'b0;
        if (start) begin
          r_ss_sel <= ss_sel;
          r_cpol   <= cpol;
          r_cpha   <= cpha;
          r_div    <= clk_div;
`ifdef SPI_LSB_FIRST_EN
          r_lsb    <= lsb_first;
`endif
          r_cnt    <= '0;
          r_edge   <= '0;
          r_rx     <= '0;
          r_sclk   <= cpol;
          r_tx     <= cpha ? tx_data : w_acc_shl;
          r_mosi   <= cpha ? 1'b0 : w_acc_bit;
        end
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_toggle) begin
          r_sclk <= ~r_sclk;
          r_edge <= r_edge + 1'b1;
        end
        if (w_sample)
          r_rx <= w_lsb ? {miso, r_rx[FRAME_WIDTH-1:1]} : {r_rx[FRAME_WIDTH-2:0], miso};
        if (w_drive) begin
          r_mosi <= w_tx_bit;
          r_tx   <= w_tx_shl;
        end
        if (r_state == HOLD && w_tick) begin
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
          r_mosi    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a cycle-stepped SPI slave model plus a scoreboard of expected rx/mosi frames.
module tb_spi_master_ctrl;
  localparam int F = 16;

  logic        clk = 1'b0;
  logic        reset, start, cpol, cpha, miso;
  logic [15:0] tx_data;
  logic [0:0]  ss_sel;
  logic [7:0]  clk_div;
  logic        busy, done, sclk, mosi;
  logic [15:0] rx_data;
  logic [1:0]  ss;
`ifdef SPI_LSB_FIRST_EN
  logic        lsb_first;
`endif

  spi_master_ctrl #(.FRAME_WIDTH(16), .SS_NUM(2), .DIV_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss(ss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] q_rx[$];
  logic [15:0] q_cap[$];

  int          o_done_cyc, o_dones, o_rises;
  bit          o_ss_ok, o_level_ok;
  logic [15:0] o_cap;
  logic [1:0]  o_ss_done;
  logic        o_busy_done;

  // Runs one transfer; the slave sends pat MSB first and records mosi into o_cap in arrival order.
  task automatic do_xfer(input logic [15:0] tx, input logic [15:0] pat, input logic [15:0] erx,
                         input logic [15:0] ecap, input logic [0:0] sel, input logic pol,
                         input logic pha, input logic [7:0] div, input int inj_cyc);
    int h, idx, run;
    logic psclk, pmosi, lead;
    logic [1:0] ess;
    logic [15:0] e;
    h = int'(div) + 1;
    ess = 2'b11;
    ess[sel] = 1'b0;
    tx_data = tx; ss_sel = sel; cpol = pol; cpha = pha; clk_div = div; miso = 1'b0;
    start = 1'b1;
    q_rx.push_back(erx);
    q_cap.push_back(ecap);
    @(posedge clk); #1;
    start = 1'b0;
    o_done_cyc = -1; o_dones = 0; o_rises = 0; o_ss_ok = 1; o_level_ok = 1; o_cap = '0;
    o_ss_done = 2'b00; o_busy_done = 1'b1;
    idx = F - 1; run = 0; psclk = pol; pmosi = 1'b0;
    for (int cyc = 1; cyc <= 1 + h*(2*F+2) + 4; cyc++) begin
      if (done) begin
        o_dones++;
        if (o_done_cyc < 0) begin
          o_done_cyc = cyc;
          o_ss_done = ss;
          o_busy_done = busy;
          if (q_rx.size() > 0) begin
            e = q_rx.pop_front();
            checks++;
            if (rx_data !== e) begin errors++; $display("FAIL sb_rx_data got %h want %h", rx_data, e); end
            e = q_cap.pop_front();
            checks++;
            if (o_cap !== e) begin errors++; $display("FAIL sb_mosi_frame got %h want %h", o_cap, e); end
          end
        end
      end
      if (busy && ss !== ess) o_ss_ok = 0;
      if (cyc == 1 && !pha) begin miso = pat[idx]; idx--; end
      if (sclk !== psclk) begin
        if (run != h) o_level_ok = 0;
        run = 0;
        if (sclk) o_rises++;
        lead = (sclk != pol);
        if (lead ^ pha) o_cap = {o_cap[14:0], pmosi};
        else if (idx >= 0) begin miso = pat[idx]; idx--; end
      end
      run++;
      psclk = sclk;
      pmosi = mosi;
      if (cyc == inj_cyc) begin start = 1'b1; tx_data = 16'hFFFF; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (q_rx.size() != 0) begin
      errors++;
      $display("FAIL sb_no_done pending %0d want 0", q_rx.size());
      q_rx.delete();
      q_cap.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tx_data = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; miso = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ss !== 2'b11)     begin errors++; $display("FAIL rst_ss got %b want 11", ss); end
    checks++; if (sclk !== 1'b0)    begin errors++; $display("FAIL rst_sclk got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0)    begin errors++; $display("FAIL rst_mosi got %b want 0", mosi); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL rst_rx got %h want 0000", rx_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_expander_write();
    do_xfer(16'hA081, 16'h1234, 16'h1234, 16'hA081, 1'b0, 1'b0, 1'b0, 8'd0, 0);
    checks++; if (o_done_cyc != 35) begin errors++; $display("FAIL m0_done_cycle got %0d want 35", o_done_cyc); end
    checks++; if (o_rises != 16)    begin errors++; $display("FAIL m0_rises got %0d want 16", o_rises); end
    checks++; if (!o_ss_ok)         begin errors++; $display("FAIL m0_ss_sel got 0 want 1"); end
    checks++; if (o_dones != 1)     begin errors++; $display("FAIL m0_done_pulses got %0d want 1", o_dones); end
    checks++; if (o_ss_done !== 2'b11 || o_busy_done !== 1'b0)
      begin errors++; $display("FAIL m0_end_state got ss=%b busy=%b want ss=11 busy=0", o_ss_done, o_busy_done); end
  endtask

  task automatic test_mode3_div();
    do_xfer(16'h5555, 16'hC3A5, 16'hC3A5, 16'h5555, 1'b1, 1'b1, 1'b1, 8'd3, 0);
    checks++; if (o_done_cyc != 137) begin errors++; $display("FAIL m3_done_cycle got %0d want 137", o_done_cyc); end
    checks++; if (!o_level_ok)       begin errors++; $display("FAIL m3_sclk_level got 0 want 1"); end
    checks++; if (!o_ss_ok)          begin errors++; $display("FAIL m3_ss_sel got 0 want 1"); end
    checks++; if (o_rises != 16)     begin errors++; $display("FAIL m3_rises got %0d want 16", o_rises); end
    checks++; if (sclk !== 1'b1)     begin errors++; $display("FAIL m3_sclk_idle got %b want 1", sclk); end
  endtask

  task automatic test_start_while_busy();
    do_xfer(16'h3C5A, 16'h0F0F, 16'h0F0F, 16'h3C5A, 1'b0, 1'b0, 1'b0, 8'd1, 20);
    checks++; if (o_dones != 1)    begin errors++; $display("FAIL busy_done_pulses got %0d want 1", o_dones); end
    checks++; if (o_done_cyc != 69) begin errors++; $display("FAIL busy_done_cycle got %0d want 69", o_done_cyc); end
  endtask

  task automatic test_reset_mid(input logic [15:0] prev_rx);
    int n_done;
    tx_data = 16'h1111; ss_sel = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; miso = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (ss !== 2'b11)     begin errors++; $display("FAIL abort_ss got %b want 11", ss); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (sclk !== 1'b0)    begin errors++; $display("FAIL abort_sclk got %b want 0", sclk); end
    checks++; if (rx_data !== prev_rx) begin errors++; $display("FAIL abort_rx got %h want %h", rx_data, prev_rx); end
    n_done = 0;
    repeat (40) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    lsb_first = 1'b1;
    do_xfer(16'h0001, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 8'd0, 0);
    checks++; if (o_done_cyc != 35) begin errors++; $display("FAIL lsb_done_cycle got %0d want 35", o_done_cyc); end
    lsb_first = 1'b0;
  endtask
`endif

  initial begin
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    test_reset();
    test_expander_write();
    test_mode3_div();
    test_start_while_busy();
    test_reset_mid(16'h0F0F);
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Synthesizable, parametrised SPI master engine that drives the gpio_expander SPI slave port and other SPI peripherals on the same bus.
- Replaces bit-banged SPI with a clocked controller.
- Configurable frame width, number of slave selects, SCLK divider and SPI mode (CPOL/CPHA).
- Sits between a host register interface (start/data handshake) and the SPI pins.

Parameters:
FRAME_WIDTH, 16, bits per transfer; the default matches the expander frame {rw, addr[6:0], data[7:0]}, where rw=1 is a write.
SS_NUM, 2, number of active-low slave-select outputs.
DIV_WIDTH, 8, width of the clk_div input.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  transfer request; sampled only in IDLE
tx_data  input  FRAME_WIDTH  frame to shift out; latched on start acceptance
ss_sel  input  $clog2(SS_NUM) (min 1)  slave index; latched on start acceptance
cpol  input  1  SCLK idle level; latched on start acceptance
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched
clk_div  input  DIV_WIDTH  half-period of SCLK = clk_div+1 clk cycles; latched
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse at end of transfer
rx_data  output  FRAME_WIDTH  frame sampled from miso; valid from the done cycle until the next done
sclk  output  1  SPI clock
mosi  output  1  SPI data out
miso  input  1  SPI data in
ss  output  SS_NUM  active-low slave selects

Behaviour:
- Reset values (synchronous, reset=1 at a rising edge):
  - sclk=0, mosi=0, ss=all ones, busy=0, done=0, rx_data=0.
  - Internal config latches clear to 0.
  - FSM goes to IDLE.
  - A reset mid-transfer aborts at once with the same values; rx_data is not updated.
- Let H = clk_div+1. Let cycle 0 be the edge where start=1 is sampled in IDLE.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - sclk = latched cpol; mosi=0.
  - On start: latch tx_data into the shift register, plus ss_sel, cpol, cpha and clk_div.
  - Go to SETUP.
  - start while busy is ignored, not queued.
- SETUP (H cycles, starting cycle 1):
  - busy=1; ss[ss_sel]=0, all other ss bits stay 1.
  - If ss_sel >= SS_NUM, no ss bit asserts; the transfer still runs.
  - CPHA=0: mosi = first bit from cycle 1.
- XFER:
  - 2*FRAME_WIDTH SCLK edges, one every H cycles; the first edge is at the end of SETUP.
  - Odd edges are leading edges (sclk leaves cpol); even edges are trailing edges.
  - CPHA=0: sample miso on leading edges; drive the next bit on trailing edges, except after the final edge.
  - CPHA=1: drive a bit on leading edges; sample miso on trailing edges.
  - Sampling shifts miso into the rx shift register.
- HOLD:
  - H cycles; sclk = cpol; ss stays asserted.
  - At the end of HOLD, on one edge: ss returns to all ones, busy=0, done=1 for one cycle, rx_data loaded, mosi=0, state goes to IDLE.
- Latency: done asserts at cycle 1 + H*(2*FRAME_WIDTH+2).
  - Example: H=1, FRAME_WIDTH=16 gives cycle 35.
- A new start is accepted on the cycle after done at the earliest.
- Bit order is MSB first. The half-period counter wraps from H-1 to 0 to generate each edge.
- clk_div=0 is legal: SCLK = clk/2.
- Input changes during busy have no effect.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- When defined:
  - Adds input port lsb_first (1 bit), latched on start acceptance.
  - lsb_first=1 shifts tx_data out LSB first and assembles rx_data so the first received bit lands in bit 0.
  - lsb_first=0 gives MSB-first behaviour.
- When undefined: the port is absent and the order is fixed MSB first. Timing is identical either way.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles -> ss=2'b11, sclk=0, mosi=0, busy=0, done=0, rx_data=16'h0000.
2. Expander write: tx_data=16'hA081 (rw=1, addr=7'h20, data=8'h81), ss_sel=0, cpol=0, cpha=0, clk_div=0; slave model returns 16'h1234 on miso -> mosi bit sequence 1010_0000_1000_0001, exactly 16 rising sclk edges, ss[0] low only, done at cycle 35, rx_data=16'h1234.
3. Mode 3 with divider: cpol=1, cpha=1, clk_div=3, tx_data=16'h5555, ss_sel=1 -> sclk idles 1, miso sampled on rising (trailing) edges, each sclk level lasts 4 cycles, done at cycle 1+4*34=137, ss[1] low throughout, rx_data equals the slave pattern.
4. Start while busy: second start with tx_data=16'hFFFF mid-transfer -> ignored, shifted frame unchanged, exactly one done pulse.
5. Reset mid-transfer: reset=1 at edge 10 of XFER -> next cycle ss=2'b11, busy=0, sclk=0, rx_data keeps its previous value, no done pulse.
6. With SPI_LSB_FIRST_EN, lsb_first=1, tx_data=16'h0001 -> mosi=1 on the first bit, then 0; a slave sending 1 then fifteen 0s gives rx_data=16'h0001.
